snoop_bus_controller: RTL
=========================

# snoop_bus_controller

Shared-bus controller and main memory for the snooping MESI multiprocessor. It accepts miss requests from the per-processor caches and arbitrates round-robin. It broadcasts the winning transaction for snooping, absorbs a writeback when a snooper aborts the memory access, and returns the line data to the requester. It is the responder end of the processor bus: caches drive miss, abort and writeback, and this block answers them.

## Interface
- NPROC, 3: number of processors/caches on the bus
- ADDR_W, 5: address width (32 one-byte lines)
- DATA_W, 8: line data width

Reset is synchronous and active-high.

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req  in  NPROC  miss request per processor; held until resp_valid
- req_write  in  NPROC  1 = write miss (read-for-ownership), 0 = read miss
- req_addr  in  NPROC*ADDR_W  request address; slice i belongs to processor i
- gnt  out  NPROC  one-hot owner of the current transaction
- bus_valid  out  1  snoop broadcast strobe
- bus_write  out  1  broadcast transaction is a write miss
- bus_addr  out  ADDR_W  broadcast address
- snoop_share  in  NPROC  snooper i holds the line (S/E)
- snoop_abort  in  NPROC  snooper i holds the line Modified and supplies a writeback
- snoop_wb_data  in  NPROC*DATA_W  writeback data from snooper i
- resp_valid  out  1  one-cycle response strobe to gnt owner
- resp_data  out  DATA_W  line data
- resp_shared  out  1  requester installs S (1) or E/M (0)

## Operation
- Internal memory: 2^ADDR_W x DATA_W registers. Reset loads mem[i] = i.
- FSM states:
  - IDLE: if any req bit is set, pick the first set bit after last_grant (wrapping), then latch id, write and addr. Go to BCAST.
  - BCAST: bus_valid=1 for exactly one cycle. Go to SNOOP.
  - SNOOP: evaluate the snoop inputs with the owner's own bits masked (& ~gnt).
    - shr = |share, abt = |abort.
    - Capture wb_data from the lowest-index aborting snooper.
    - If abt, go to WB; otherwise go to READ.
  - WB: mem[addr] <= captured wb_data. Go to READ.
  - READ: rdata <= mem[addr]. This returns the WB value written the previous cycle. Go to RESP.
  - RESP: resp_valid=1, resp_data=rdata.
    - resp_shared = ~write & (shr | abt). Write misses always return 0.
    - Set last_grant = id. Go to IDLE.
- gnt is one-hot from BCAST through RESP and 0 in IDLE.
- bus_write and bus_addr are valid whenever gnt≠0. They are 0 in IDLE.
- req, req_write and req_addr changes after IDLE is exited are ignored. The latched transaction always completes.
- A req still high in IDLE after RESP is a new request. Requesters clear req on the edge where they see resp_valid.
- Writes by the requester to its own line after a write miss stay in its cache. Memory is written only in WB.
- Multiple aborters (illegal under MESI): lowest index wins, the others are ignored.
- Reset at any point:
  - Next state is IDLE; all outputs go to 0.
  - last_grant = NPROC-1, so processor 0 has top priority.
  - A pending writeback is dropped and memory is reloaded with mem[i] = i.

## Timing
- Reset values: gnt=0, bus_valid=0, bus_write=0, bus_addr=0, resp_valid=0, resp_data=0, resp_shared=0.
- Let cycle t be the IDLE cycle in which req is sampled high.
  - BCAST at t+1, SNOOP at t+2.
  - No abort: READ at t+3, resp_valid at t+4 (latency 4).
  - Abort: WB at t+3, READ at t+4, resp_valid at t+5 (latency 5).
- Snoopers must present share/abort/wb_data registered off the BCAST edge. They are sampled only at the end of SNOOP.
- Back-to-back transactions: minimum 5 cycles per transaction (IDLE included). Another pending req is granted at the IDLE that follows RESP.
- All outputs are registered/state-decoded. There are no combinational paths from inputs to outputs.

## Test plan
- Reset, then P0 read miss at addr 5 with no snoop response -> gnt=001 at t+1..t+4, bus_valid only at t+1, resp_valid at t+4, resp_data=0x05, resp_shared=0.
- P1 read miss at addr 9 with snoop_share[2]=1 -> resp_data=0x09, resp_shared=1, latency 4.
- P0 write miss at addr 3 with snoop_abort[2]=1, wb_data=0xA5 -> resp_valid at t+5, resp_data=0xA5, resp_shared=0. A following P1 read of addr 3 returns 0xA5, shared=0.
- req=111 held after reset, each requester dropping req after its response -> grants in order 001, 010, 100. Then P0 and P2 re-request together -> 001 is served before 100.
- P1 read miss at addr 7 with snoop_abort[1]=1 and snoop_share[1]=1 (own bits) -> no WB, latency 4, resp_data=0x07, resp_shared=0.
- Reset asserted during WB of the abort test -> next cycle all outputs are 0 and state is IDLE. A later read of addr 3 returns 0x03.

Source files
------------

// File: rtl/snoop_bus_controller.sv
// Shared snooping bus controller with main memory: round-robin miss arbitration,
// snoop broadcast, Modified-line writeback absorption and line response.
module snoop_bus_controller #(
    parameter int NPROC  = 3,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NPROC-1:0]         req,
    input  logic [NPROC-1:0]         req_write,
    input  logic [NPROC*ADDR_W-1:0]  req_addr,
    output logic [NPROC-1:0]         gnt,
    output logic                     bus_valid,
    output logic                     bus_write,
    output logic [ADDR_W-1:0]        bus_addr,
    input  logic [NPROC-1:0]         snoop_share,
    input  logic [NPROC-1:0]         snoop_abort,
    input  logic [NPROC*DATA_W-1:0]  snoop_wb_data,
    output logic                     resp_valid,
    output logic [DATA_W-1:0]        resp_data,
    output logic                     resp_shared
);

    localparam int ID_W  = (NPROC > 1) ? $clog2(NPROC) : 1;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BCAST,
        S_SNOOP,
        S_WB,
        S_READ,
        S_RESP
    } state_t;

    state_t              state, state_next;
    logic [ID_W-1:0]     owner_id, last_grant, pick_id;
    logic [NPROC-1:0]    owner_oh;
    logic                owner_write;
    logic [ADDR_W-1:0]   owner_addr;
    logic [NPROC-1:0]    share_m, abort_m;
    logic                shr, abt;
    logic [DATA_W-1:0]   wb_sel, wb_data, rdata;
    logic [DATA_W-1:0]   mem [DEPTH];

    // First requester strictly after `last`, wrapping back to `last` itself.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NPROC-1:0] r,
                                                 input logic [ID_W-1:0]  last);
        logic [ID_W-1:0] pick;
        int              idx;
        pick = last;
        for (int k = NPROC; k >= 1; k--) begin
            idx = (int'(last) + k) % NPROC;
            if (r[ID_W'(idx)]) pick = ID_W'(idx);
        end
        return pick;
    endfunction

    assign pick_id = rr_pick(req, last_grant);

    // The requester never snoops its own transaction.
    assign share_m = snoop_share & ~owner_oh;
    assign abort_m = snoop_abort & ~owner_oh;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wb_sel = '0;
        for (int i = NPROC - 1; i >= 0; i--) begin
            if (abort_m[i]) wb_sel = snoop_wb_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (|req) state_next = S_BCAST;
            S_BCAST: state_next = S_SNOOP;
            S_SNOOP: state_next = (|abort_m) ? S_WB : S_READ;
            S_WB:    state_next = S_READ;
            S_READ:  state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            owner_id    <= '0;
            owner_oh    <= '0;
            owner_write <= 1'b0;
            owner_addr  <= '0;
            last_grant  <= ID_W'(NPROC - 1);
            shr         <= 1'b0;
            abt         <= 1'b0;
            wb_data     <= '0;
            rdata       <= '0;
            // NOTE: the memory is deliberately reset (identity contents), so it is built from flops, not a RAM macro.
            for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(i);
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        owner_id    <= pick_id;
                        owner_oh    <= NPROC'(1) << pick_id;
                        owner_write <= req_write[pick_id];
                        owner_addr  <= req_addr[int'(pick_id)*ADDR_W +: ADDR_W];
                    end
                end
                S_SNOOP: begin
                    shr     <= |share_m;
                    abt     <= |abort_m;
                    wb_data <= wb_sel;
                end
                S_WB:    mem[owner_addr] <= wb_data;
                S_READ:  rdata <= mem[owner_addr];
                S_RESP:  last_grant <= owner_id;
                default: ;
            endcase
        end
    end

    // Outputs are decoded from registered state only; idle values are all zero.
    assign gnt         = (state != S_IDLE) ? owner_oh : '0;
    assign bus_valid   = (state == S_BCAST);
    assign bus_write   = (state != S_IDLE) & owner_write;
    assign bus_addr    = (state != S_IDLE) ? owner_addr : '0;
    assign resp_valid  = (state == S_RESP);
    assign resp_data   = resp_valid ? rdata : '0;
    assign resp_shared = resp_valid & ~owner_write & (shr | abt);

endmodule
